// File: rtl/seq_add_sub_if.sv
// Operand/result bundle for the multi-cycle adder/subtractor.
// master drives the request side; slave is the arithmetic unit.
interface seq_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic             sat;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sub, sat, a, b,
        input  busy, done, result, cout, ovf, zero
    );

    modport slave (
        input  start, sub, sat, a, b,
        output busy, done, result, cout, ovf, zero
    );
endinterface

// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands summed CHUNK bits per
// clock, carry held in a flop between slices, start/done handshake.
// Optional signed saturation is built only when ADDSUB_SAT_EN is defined.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last committed result
// RUN   | one slice per cycle, LSB slice first; commit after last slice
module seq_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_add_sub_if.slave bus
);
    localparam int N     = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("seq_add_sub: CHUNK must be >= 1 and divide WIDTH");
    end
    if ($bits(bus.a) != WIDTH) begin : g_bad_if_width
        $error("seq_add_sub: interface WIDTH differs from module WIDTH");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
`ifdef ADDSUB_SAT_EN
    logic               sat_q, sat_d;
`endif

    logic [CHUNK-1:0]   slice_a;
    logic [CHUNK-1:0]   slice_b;
    logic [CHUNK:0]     slice_sum;
    logic [WIDTH-1:0]   work_next;
    logic               msb_cin;
    logic               ovf_fin;
    logic [WIDTH-1:0]   res_fin;

    // Slice datapath: operands shift right so the active slice is always in
    // the low bits; the working register fills from the top, LSB slice first.
    always_comb begin
        slice_a   = op_a_q[CHUNK-1:0];
        slice_b   = op_b_q[CHUNK-1:0];
        slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + (CHUNK+1)'(carry_q);
        work_next = (work_q >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        // On the last slice this is the carry into the word MSB.
        msb_cin   = slice_sum[CHUNK-1] ^ slice_a[CHUNK-1] ^ slice_b[CHUNK-1];
        ovf_fin   = msb_cin ^ slice_sum[CHUNK];
        res_fin   = work_next;
`ifdef ADDSUB_SAT_EN
        // On the last slice slice_a's top bit is operand A's sign.
        if (sat_q && ovf_fin) begin
            res_fin = slice_a[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Next-state and register updates for the IDLE/RUN sequencer.
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        work_d   = work_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
`ifdef ADDSUB_SAT_EN
        sat_d    = sat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_a_d  = bus.a;
                    op_b_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = CNT_W'(N - 1);
`ifdef ADDSUB_SAT_EN
                    sat_d   = bus.sat;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                op_a_d  = op_a_q >> CHUNK;
                op_b_d  = op_b_q >> CHUNK;
                work_d  = work_next;
                carry_d = slice_sum[CHUNK];
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    result_d = res_fin;
                    cout_d   = slice_sum[CHUNK];
                    ovf_d    = ovf_fin;
                    zero_d   = (res_fin == '0);
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            work_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
`ifdef ADDSUB_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            work_q   <= work_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
`ifdef ADDSUB_SAT_EN
            sat_q    <= sat_d;
`endif
        end
    end

    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub (WIDTH=32, CHUNK=8). Expected values come from a
// plain-arithmetic model; honours ADDSUB_SAT_EN when defined.
module tb_seq_add_sub;
    localparam int LAT = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_add_sub_if #(.WIDTH(32)) bus ();

    seq_add_sub #(.WIDTH(32), .CHUNK(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: integer arithmetic on the operands as unsigned and signed values.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                         input logic msub, input logic msat,
                         output logic [31:0] r, output logic c,
                         output logic o, output logic z);
        logic [32:0] full;
        longint      t;
        if (msub) begin
            full = {1'b0, ma} - {1'b0, mb};
            c    = (ma >= mb);
            t    = longint'($signed(ma)) - longint'($signed(mb));
        end else begin
            full = {1'b0, ma} + {1'b0, mb};
            c    = full[32];
            t    = longint'($signed(ma)) + longint'($signed(mb));
        end
        r = full[31:0];
        o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
`ifdef ADDSUB_SAT_EN
        if (msat && o) r = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
        if (msat) r = full[31:0];
`endif
        z = (r == 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                         input logic ts, input logic tsat);
        logic [31:0] er;
        logic        ec, eo, ez;
        logic [31:0] prev;
        int          n;
        model(ta, tbv, ts, tsat, er, ec, eo, ez);
        prev      = bus.result;
        bus.a     = ta;
        bus.b     = tbv;
        bus.sub   = ts;
        bus.sat   = tsat;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.sub   = 1'($urandom);
        bus.sat   = 1'($urandom);
        n = 0;
        while (!bus.done && n < 20) begin
            chk({tag, ".busy"}, bus.busy, 1'b1);
            chk({tag, ".hold"}, bus.result, prev);
            tick();
            n++;
        end
        chk({tag, ".latency"}, n, LAT);
        chk({tag, ".busy_at_done"}, bus.busy, 1'b0);
        chk({tag, ".result"}, bus.result, er);
        chk({tag, ".cout"}, bus.cout, ec);
        chk({tag, ".ovf"}, bus.ovf, eo);
        chk({tag, ".zero"}, bus.zero, ez);
        tick();
        chk({tag, ".done_pulse"}, bus.done, 1'b0);
        chk({tag, ".result_stable"}, bus.result, er);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_00FF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] er1, er2, er3;
        logic        ec, eo, ez;
        logic [31:0] xa, xb;
        logic        xs, xt;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.sat   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (2) tick();
        chk("rst.busy", bus.busy, 1'b0);
        chk("rst.done", bus.done, 1'b0);
        chk("rst.result", bus.result, 32'd0);
        chk("rst.cout", bus.cout, 1'b0);
        chk("rst.ovf", bus.ovf, 1'b0);
        chk("rst.zero", bus.zero, 1'b0);
        rst_n = 1'b1;
        repeat (8) begin
            tick();
            chk("idle.busy", bus.busy, 1'b0);
            chk("idle.done", bus.done, 1'b0);
        end
        chk("idle.result", bus.result, 32'd0);
        chk("idle.zero", bus.zero, 1'b0);

        do_op("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        do_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        do_op("sub_5_5",    32'd5,         32'd5,         1'b1, 1'b0);
        do_op("sub_3_5",    32'd3,         32'd5,         1'b1, 1'b0);
        do_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        do_op("add_ovfsat", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        do_op("sub_ovfsat", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        do_op("add_negsat", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            xa = rand_operand();
            xb = rand_operand();
            xs = 1'($urandom);
            xt = 1'($urandom);
            do_op("rand", xa, xb, xs, xt);
        end

        // start pulsed while busy must be ignored
        model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, er1, ec, eo, ez);
        bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.sub = 1'b0; bus.sat = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.a = 32'hDEAD_BEEF; bus.b = 32'h0BAD_F00D; bus.sub = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("ign.done", bus.done, 1'b1);
        chk("ign.result", bus.result, er1);
        repeat (6) begin
            tick();
            chk("ign.no_second_done", bus.done, 1'b0);
            chk("ign.no_busy", bus.busy, 1'b0);
        end

        // start held through done: second op accepted in the done cycle
        model(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, er1, ec, eo, ez);
        model(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, er2, ec, eo, ez);
        bus.a = 32'h0000_1000; bus.b = 32'h0000_0234; bus.sub = 1'b0; bus.start = 1'b1;
        tick();
        bus.a = 32'h0000_0010; bus.b = 32'h0000_0020; bus.sub = 1'b1;
        repeat (3) begin
            tick();
            chk("held.busy1", bus.busy, 1'b1);
            chk("held.nodone1", bus.done, 1'b0);
        end
        tick();
        chk("held.done1", bus.done, 1'b1);
        chk("held.result1", bus.result, er1);
        tick();
        chk("held.accept2", bus.busy, 1'b1);
        chk("held.done1_pulse", bus.done, 1'b0);
        bus.start = 1'b0;
        repeat (3) begin
            tick();
            chk("held.nodone2", bus.done, 1'b0);
        end
        tick();
        chk("held.done2", bus.done, 1'b1);
        chk("held.result2", bus.result, er2);
        chk("held.cout2", bus.cout, ec);
        chk("held.ovf2", bus.ovf, eo);
        tick();
        chk("held.no_third", bus.busy, 1'b0);

        // reset two cycles into RUN aborts without a commit
        bus.a = 32'h0F0F_0F0F; bus.b = 32'h0101_0101; bus.sub = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort.busy", bus.busy, 1'b0);
        chk("abort.done", bus.done, 1'b0);
        chk("abort.result", bus.result, 32'd0);
        chk("abort.cout", bus.cout, 1'b0);
        chk("abort.ovf", bus.ovf, 1'b0);
        chk("abort.zero", bus.zero, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            chk("abort.no_done", bus.done, 1'b0);
            chk("abort.result_held", bus.result, 32'd0);
        end
        model(32'hFFFF_FF00, 32'h0000_0100, 1'b0, 1'b0, er3, ec, eo, ez);
        do_op("after_abort", 32'hFFFF_FF00, 32'h0000_0100, 1'b0, 1'b0);
        chk("after_abort.zero_model", bus.zero, ez);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
